pixel_frame_sink: RTL and testbench
===================================

PIXEL_FRAME_SINK -- requirements
Module: pixel_frame_sink

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 1024, pixels per frame; must be a multiple of 4.
REQ-002 SHALL have parameter WADDR_W, default 8, word address width; 2**WADDR_W >= FRAME_PIXELS/4.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  level arm; high starts capture, low aborts or re-arms.
REQ-006 SHALL have port hold  input  1  injected backpressure; forces READY_OUT low.
REQ-007 SHALL have port pixel_in  input  8  processed pixel from data_proc.
REQ-008 SHALL have port VALID_IN  input  1  pixel_in valid.
REQ-009 SHALL have port READY_OUT  output  1  sink accepts pixel this cycle.
REQ-010 SHALL have port rd_en  input  1  frame buffer read strobe.
REQ-011 SHALL have port rd_addr  input  WADDR_W  frame buffer word address.
REQ-012 SHALL have port rd_data  output  32  registered read data.
REQ-013 SHALL have port frame_done  output  1  full frame captured.
REQ-014 SHALL have port pix_count  output  $clog2(FRAME_PIXELS)+1  pixels accepted this frame.
REQ-015 SHALL have port checksum  output  16  modular sum of accepted pixels.
REQ-016 SHALL have port busy  output  1  high in CAPTURE.

Function
REQ-017 SHALL implement states IDLE, CAPTURE, DONE; IDLE->CAPTURE when start=1; CAPTURE->DONE on the FRAME_PIXELS-th transfer; DONE->IDLE when start=0; CAPTURE->IDLE when start=0 (abort).
REQ-018 SHALL drive READY_OUT = (state==CAPTURE) && !hold; transfer = VALID_IN && READY_OUT; VALID_IN without READY_OUT has no effect.
REQ-019 SHALL clear pix_count, checksum and the byte-lane pointer on the IDLE->CAPTURE edge.
REQ-020 SHALL place transfer k in word k/4, byte lane k%4 (bits 8*(k%4)+7:8*(k%4)), little-endian.
REQ-021 SHALL write the completed word to the frame buffer on the same edge that accepts its 4th byte.
REQ-022 SHALL increment pix_count by 1 and add pixel_in to checksum (mod 2**16) per transfer.
REQ-023 SHALL assert frame_done and drop busy the cycle after the final transfer; READY_OUT 0 throughout DONE.
REQ-024 SHALL hold pix_count, checksum and frame buffer in DONE and after abort until next CAPTURE entry.
REQ-025 SHALL discard a partial word on abort; frame_done stays 0.
REQ-026 SHALL return rd_data one cycle after rd_en; read/write same address same cycle returns old data; rd_data holds when rd_en=0.
REQ-027 SHALL allow reads in any state; hold SHALL NOT affect state transitions.

Reset
REQ-028 SHALL on rstn=0 immediately force state IDLE and READY_OUT, rd_data, frame_done, pix_count, checksum, busy to 0.
REQ-029 SHALL NOT reset frame buffer contents; reset mid-frame abandons the frame.

Structure
REQ-030 SHALL place the state enum, FRAME_PIXELS default and byte-lane width constants in shared package pixel_sink_pkg.
REQ-031 SHALL instantiate one sub-module frame_word_ram: simple dual-port, 32-bit, 2**WADDR_W words, sync write, registered read.

Verification
REQ-032 start=1, 1024 pixels k&0xFF, VALID_IN constant -> frame_done after transfer 1024, pix_count=1024, word0=0x03020100, word63=0xFFFEFDFC, checksum=0xFE00.
REQ-033 same stream, hold toggling every cycle -> READY_OUT low whenever hold=1, identical buffer and checksum, no loss or duplication.
REQ-034 abort: start dropped after 10 pixels -> IDLE, frame_done=0, pix_count=10; start=1 again -> pix_count 0, word0 rewritten by new data.
REQ-035 in DONE with VALID_IN=1 for 20 cycles -> READY_OUT=0, pix_count stays 1024; start 0 then 1 -> new capture starts.
REQ-036 rstn pulsed low after 500 pixels -> outputs 0 asynchronously, IDLE; subsequent full frame matches REQ-032.

Source files
------------

// File: rtl/pixel_sink_pkg.sv
// Shared types and constants for the pixel frame sink: FSM states, frame default, byte-lane geometry.
// Pure declarations; no timing or flow control of its own.
package pixel_sink_pkg;

  localparam int FRAME_PIXELS_DEF = 1024;
  localparam int LANE_W           = 8;
  localparam int LANES            = 4;
  localparam int LANE_IDX_W       = 2;
  localparam int WORD_W           = LANE_W * LANES;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } sink_state_t;

endpackage

// File: rtl/frame_word_ram.sv
// Simple dual-port word RAM: synchronous write, registered read with 1-cycle latency.
// No backpressure; read-during-write to the same address returns the old word.
module frame_word_ram
  import pixel_sink_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = WORD_W
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Storage is deliberately left out of reset so a reset never wipes a captured frame.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pixel_frame_sink.sv
// Captures one frame of 8-bit pixels into a 32-bit word buffer with count and checksum; READY_OUT is combinational.
// Transfer retires on the accepting edge, buffer reads return 1 cycle after rd_en; hold or a non-CAPTURE state stalls the source.
module pixel_frame_sink
  import pixel_sink_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int WADDR_W      = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic                          hold,
  input  logic [LANE_W-1:0]             pixel_in,
  input  logic                          VALID_IN,
  output logic                          READY_OUT,
  input  logic                          rd_en,
  input  logic [WADDR_W-1:0]            rd_addr,
  output logic [WORD_W-1:0]             rd_data,
  output logic                          frame_done,
  output logic [$clog2(FRAME_PIXELS):0] pix_count,
  output logic [15:0]                   checksum,
  output logic                          busy
);

  localparam int PC_W = $clog2(FRAME_PIXELS) + 1;

  sink_state_t                  state;
  logic [LANE_IDX_W-1:0]        lane;
  logic [WADDR_W-1:0]           waddr;
  logic [(LANES-1)*LANE_W-1:0]  word_acc;
  logic                         xfer;
  logic                         word_we;
  logic                         last_xfer;
  logic [WORD_W-1:0]            word_wdata;

  assign READY_OUT  = (state == ST_CAPTURE) && !hold;
  assign xfer       = VALID_IN && READY_OUT;
  assign word_we    = xfer && (lane == LANE_IDX_W'(LANES - 1));
  assign last_xfer  = xfer && (pix_count == PC_W'(FRAME_PIXELS - 1));
  // Lower three bytes shift in from the top, so the oldest pixel lands in lane 0.
  assign word_wdata = {pixel_in, word_acc};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pix_count  <= '0;
      checksum   <= '0;
      lane       <= '0;
      waddr      <= '0;
      word_acc   <= '0;
    end else begin
      if (xfer) begin
        pix_count <= pix_count + 1'b1;
        checksum  <= checksum + {8'h00, pixel_in};
        lane      <= lane + 1'b1;
        word_acc  <= {pixel_in, word_acc[(LANES-1)*LANE_W-1:LANE_W]};
        if (word_we) begin
          waddr <= waddr + 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_CAPTURE;
            busy       <= 1'b1;
            frame_done <= 1'b0;
            pix_count  <= '0;
            checksum   <= '0;
            lane       <= '0;
            waddr      <= '0;
          end
        end
        ST_CAPTURE: begin
          // Abort wins over completion; a pixel accepted on that edge is still counted.
          if (!start) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (last_xfer) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!start) begin
            state      <= ST_IDLE;
            frame_done <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

  frame_word_ram #(
    .AW (WADDR_W),
    .DW (WORD_W)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (word_we),
    .waddr (waddr),
    .wdata (word_wdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_pixel_frame_sink.sv
// Directed bench for pixel_frame_sink: a short vector table, then full-frame, hold, DONE, abort and reset sequences.
module tb_pixel_frame_sink;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        hold;
  logic [7:0]  pixel_in;
  logic        VALID_IN;
  logic        READY_OUT;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        frame_done;
  logic [10:0] pix_count;
  logic [15:0] checksum;
  logic        busy;

  int checks = 0;
  int errors = 0;

  pixel_frame_sink #(
    .FRAME_PIXELS (1024),
    .WADDR_W      (8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .hold       (hold),
    .pixel_in   (pixel_in),
    .VALID_IN   (VALID_IN),
    .READY_OUT  (READY_OUT),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .pix_count  (pix_count),
    .checksum   (checksum),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        hold;
    logic        valid;
    logic [7:0]  pix;
    logic        e_ready;
    logic        e_busy;
    logic        e_done;
    logic [10:0] e_pc;
    logic [15:0] e_cs;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    @(negedge clk);
    rd_en   = 1'b1;
    rd_addr = 8'(a);
    @(negedge clk);
    d     = rd_data;
    rd_en = 1'b0;
  endtask

  // Pushes n transfers of (base+k)&0xFF; counts a transfer only when READY_OUT is seen high.
  task automatic stream(input int n, input bit tog, input int base, input string tag);
    int  k    = 0;
    int  cyc  = 0;
    int  viol = 0;
    logic h   = 1'b0;
    while (k < n && cyc < 4 * n + 10) begin
      @(negedge clk);
      h        = tog ? ~h : 1'b0;
      hold     = h;
      VALID_IN = 1'b1;
      pixel_in = 8'(base + k);
      #1;
      if (hold && READY_OUT) viol++;
      if (READY_OUT) k++;
      cyc++;
    end
    @(negedge clk);
    VALID_IN = 1'b0;
    hold     = 1'b0;
    check({tag, "_transfers"}, k, n);
    if (tog) check({tag, "_hold_blocks_ready"}, viol, 0);
  endtask

  task automatic check_frame(input string tag);
    logic [31:0] d;
    logic [31:0] exp;
    int bad = 0;
    check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_pix_count"}, {21'd0, pix_count}, 32'd1024);
    check({tag, "_checksum"}, {16'd0, checksum}, 32'h0000FE00);
    for (int w = 0; w < 256; w++) begin
      rd(w, d);
      exp = {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)};
      if (w == 0)  check({tag, "_word0"}, d, 32'h03020100);
      if (w == 63) check({tag, "_word63"}, d, 32'hFFFEFDFC);
      if (d !== exp) bad++;
    end
    check({tag, "_bad_words"}, bad, 0);
  endtask

  task automatic run_frame(input bit tog, input string tag);
    start = 1'b1;
    stream(1024, tog, 0, tag);
    check_frame(tag);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] d_prev;
    int viol;

    rstn = 1'b0; start = 1'b0; hold = 1'b0; pixel_in = 8'h00;
    VALID_IN = 1'b0; rd_en = 1'b0; rd_addr = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_rd_data", rd_data, 32'h0);
    rstn = 1'b1;

    //              start hold valid pix    rdy busy done pc     cs
    tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 11'd0, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 11'd0, 16'h0000};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 11'd1, 16'h0010};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 11'd1, 16'h0010};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h30, 1'b1, 1'b1, 1'b0, 11'd1, 16'h0010};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h30, 1'b1, 1'b1, 1'b0, 11'd2, 16'h0040};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 8'h40, 1'b1, 1'b1, 1'b0, 11'd3, 16'h0080};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 11'd4, 16'h017F};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 11'd4, 16'h017F};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 11'd4, 16'h017F};

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = tbl[i].start; hold = tbl[i].hold;
      VALID_IN = tbl[i].valid; pixel_in = tbl[i].pix;
      #1;
      check($sformatf("vec%0d_ready", i), {31'd0, READY_OUT}, {31'd0, tbl[i].e_ready});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
      check($sformatf("vec%0d_done", i), {31'd0, frame_done}, {31'd0, tbl[i].e_done});
      check($sformatf("vec%0d_pix_count", i), {21'd0, pix_count}, {21'd0, tbl[i].e_pc});
      check($sformatf("vec%0d_checksum", i), {16'd0, checksum}, {16'd0, tbl[i].e_cs});
    end
    rd(0, d);
    check("vec_word0", d, 32'hFF403010);
    d_prev = d;
    repeat (2) @(negedge clk);
    check("rd_data_holds", rd_data, d_prev);

    run_frame(1'b0, "full");

    // Sitting in DONE with a valid source must not accept anything.
    viol = 0;
    VALID_IN = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      pixel_in = 8'(c);
      #1;
      if (READY_OUT) viol++;
    end
    VALID_IN = 1'b0;
    check("done_ready_low", viol, 0);
    check("done_pix_count", {21'd0, pix_count}, 32'd1024);
    check("done_frame_done", {31'd0, frame_done}, 32'd1);
    start = 1'b0;
    @(negedge clk);
    check("done_exit_frame_done", {31'd0, frame_done}, 32'd0);
    start = 1'b1;
    @(negedge clk);
    check("recapture_busy", {31'd0, busy}, 32'd1);
    check("recapture_pix_count", {21'd0, pix_count}, 32'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Abort after 10 pixels: two complete words land, the partial third does not.
    start = 1'b1;
    stream(10, 1'b0, 8'hA0, "abort");
    start = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_frame_done", {31'd0, frame_done}, 32'd0);
    check("abort_pix_count", {21'd0, pix_count}, 32'd10);
    rd(0, d);
    check("abort_word0", d, 32'hA3A2A1A0);
    rd(2, d);
    check("abort_word2_kept", d, 32'h0B0A0908);
    start = 1'b1;
    @(negedge clk);
    check("restart_pix_count", {21'd0, pix_count}, 32'd0);
    stream(4, 1'b0, 8'h11, "restart");
    rd(0, d);
    check("restart_word0", d, 32'h14131211);
    start = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(1'b1, "hold");
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-frame, then a clean frame.
    start = 1'b1;
    stream(500, 1'b0, 0, "pre_reset");
    #2;
    rstn = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, READY_OUT}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_pix_count", {21'd0, pix_count}, 32'd0);
    check("rst_checksum", {16'd0, checksum}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run_frame(1'b0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
